circ_queue: RTL and testbench

CIRC_QUEUE -- requirements
Module: circ_queue

---
 rtl/circ_queue.sv | 107 ++++++++++
 tb/tb_circ_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/circ_queue.sv
// circ_queue
// ----------
// Single-clock circular FIFO queue with a ready/valid handshake on both sides.
// Head and tail pointers carry one extra wrap flag above the index. Equal
// pointers mean empty. Equal indices with differing flags mean full. Only the
// pointers are reset; the storage array is left uninitialised.
//
// Parameters
//   WIDTH        payload width in bits
//   DEPTH        number of entries (power of 2, >= 2)
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset (pointers only)
//   flush_i      synchronous flush; discards all entries at the next edge
//   enq_valid_i  producer offers enq_data_i
//   enq_ready_o  queue can accept an entry this cycle (not full)
//   enq_data_i   entry payload
//   deq_valid_o  head entry is valid (not empty)
//   deq_ready_i  consumer takes the head entry
//   deq_data_o   head entry payload, all-zeros while empty
//   count_o      current occupancy, 0..DEPTH
//   full_o       queue holds DEPTH entries
//   empty_o      queue holds no entries

module circ_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              enq_valid_i,
   output logic              enq_ready_o,
   input  logic [WIDTH-1:0]  enq_data_i,
   output logic              deq_valid_o,
   input  logic              deq_ready_i,
   output logic [WIDTH-1:0]  deq_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int IDXW = $clog2(DEPTH);

   // Pointer layout: {wrap flag, index}. Because DEPTH is a power of two, a
   // plain +1 on the whole pointer wraps the index to 0 and toggles the flag.
   localparam logic [IDXW:0] PTR_ONE  = (IDXW+1)'(1);
   localparam logic [IDXW:0] PTR_ZERO = '0;

   logic [IDXW:0]     head;
   logic [IDXW:0]     tail;
   logic [IDXW-1:0]   head_idx;
   logic [IDXW-1:0]   tail_idx;
   logic              enq_fire;
   logic              deq_fire;
   logic [WIDTH-1:0]  storage [DEPTH];

   assign head_idx = head[IDXW-1:0];
   assign tail_idx = tail[IDXW-1:0];

   // Status is derived purely from the pointers, so the enqueue side never
   // looks at deq_ready_i: a full queue refuses an offer even if the head
   // leaves in the same cycle.
   assign empty_o     = (head == tail);
   assign full_o      = (head_idx == tail_idx) && (head[IDXW] != tail[IDXW]);
   assign enq_ready_o = !full_o;
   assign deq_valid_o = !empty_o;

   assign enq_fire = enq_valid_i && enq_ready_o;
   assign deq_fire = deq_valid_o && deq_ready_i;

   // Modular difference of the extended pointers is the occupancy; the flag
   // bit makes the full case come out as DEPTH rather than 0.
   assign count_o = tail - head;

   // The head slot is masked while empty so stale storage never leaks out.
   assign deq_data_o = empty_o ? '0 : storage[head_idx];

   // Pointer registers. Flush has priority over any handshake in the same
   // cycle, so enqueue and dequeue during a flush are both dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= PTR_ZERO;
         tail <= PTR_ZERO;
      end else if (flush_i) begin
         head <= PTR_ZERO;
         tail <= PTR_ZERO;
      end else begin
         if (enq_fire) begin
            tail <= tail + PTR_ONE;
         end
         if (deq_fire) begin
            head <= head + PTR_ONE;
         end
      end
   end

   // Storage write. Not reset: validity is tracked entirely by the pointers.
   // A write during a flush is harmless but suppressed to keep intent clear.
   always_ff @(posedge clk) begin
      if (enq_fire && !flush_i) begin
         storage[tail_idx] <= enq_data_i;
      end
   end

endmodule

// File: tb/tb_circ_queue.sv
// tb_circ_queue
// -------------
// Self-checking bench for circ_queue (DEPTH=4, WIDTH=32). A table of directed
// vectors covers fill/overflow/drain, hand-written sequences cover the
// multi-cycle corner cases (wrap, full with concurrent dequeue, flush,
// asynchronous reset), and a random phase compares against a queue model.

module tb_circ_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush_i;
   logic              enq_valid_i;
   logic              enq_ready_o;
   logic [WIDTH-1:0]  enq_data_i;
   logic              deq_valid_o;
   logic              deq_ready_i;
   logic [WIDTH-1:0]  deq_data_o;
   logic [2:0]        count_o;
   logic              full_o;
   logic              empty_o;

   int checks = 0;
   int errors = 0;

   // Reference model: a plain queue of payloads, front = head entry.
   logic [WIDTH-1:0] model_q [$];

   typedef struct {
      logic        ev;
      logic [31:0] data;
      logic        dr;
      logic        fl;
      int          exp_count;
      logic        exp_full;
      logic        exp_empty;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   circ_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .enq_valid_i (enq_valid_i),
      .enq_ready_o (enq_ready_o),
      .enq_data_i  (enq_data_i),
      .deq_valid_o (deq_valid_o),
      .deq_ready_i (deq_ready_i),
      .deq_data_o  (deq_data_o),
      .count_o     (count_o),
      .full_o      (full_o),
      .empty_o     (empty_o)
   );

   // Single comparison point: every check bumps the counters here.
   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare all DUT outputs with what the model says the queue holds now.
   task automatic checkOutput(input string tag);
      int n;
      logic [31:0] exp_data;
      n = model_q.size();
      exp_data = (n > 0) ? model_q[0] : 32'h0;
      checkVal({tag, ".count"},     32'(count_o),     32'(n));
      checkVal({tag, ".empty"},     32'(empty_o),     32'(n == 0));
      checkVal({tag, ".full"},      32'(full_o),      32'(n == DEPTH));
      checkVal({tag, ".enq_ready"}, 32'(enq_ready_o), 32'(n != DEPTH));
      checkVal({tag, ".deq_valid"}, 32'(deq_valid_o), 32'(n != 0));
      checkVal({tag, ".deq_data"},  deq_data_o,       exp_data);
   endtask

   // Drive one cycle: inputs change at the falling edge, the pre-edge state is
   // checked against the model, then the model steps at the rising edge.
   task automatic applyStimulus(input logic ev, input logic [31:0] d, input logic dr,
                                input logic fl, input string tag);
      bit enq_ok;
      bit deq_ok;
      @(negedge clk);
      enq_valid_i = ev;
      enq_data_i  = d;
      deq_ready_i = dr;
      flush_i     = fl;
      checkOutput(tag);
      enq_ok = ev && (model_q.size() < DEPTH);
      deq_ok = dr && (model_q.size() > 0);
      @(posedge clk);
      if (fl) begin
         model_q.delete();
      end else begin
         if (deq_ok) void'(model_q.pop_front());
         if (enq_ok) model_q.push_back(d);
      end
   endtask

   task automatic addVec(input logic ev, input logic [31:0] d, input logic dr, input logic fl,
                         input int c, input logic f, input logic e, input logic [31:0] x);
      vec_t v;
      v.ev = ev; v.data = d; v.dr = dr; v.fl = fl;
      v.exp_count = c; v.exp_full = f; v.exp_empty = e; v.exp_data = x;
      vecs.push_back(v);
   endtask

   // Watchdog so the run always ends even if something stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n       = 1'b0;
      flush_i     = 1'b0;
      enq_valid_i = 1'b0;
      enq_data_i  = '0;
      deq_ready_i = 1'b0;

      // Reset state, observed while reset is held.
      #12;
      checkVal("reset.empty",     32'(empty_o),     32'd1);
      checkVal("reset.full",      32'(full_o),      32'd0);
      checkVal("reset.enq_ready", 32'(enq_ready_o), 32'd1);
      checkVal("reset.deq_valid", 32'(deq_valid_o), 32'd0);
      checkVal("reset.count",     32'(count_o),     32'd0);
      checkVal("reset.deq_data",  deq_data_o,       32'd0);
      rst_n = 1'b1;

      // Fill to full, offer a fifth entry, then drain in order.
      addVec(1, 32'h11, 0, 0, 1, 0, 0, 32'h11);
      addVec(1, 32'h22, 0, 0, 2, 0, 0, 32'h11);
      addVec(1, 32'h33, 0, 0, 3, 0, 0, 32'h11);
      addVec(1, 32'h44, 0, 0, 4, 1, 0, 32'h11);
      addVec(1, 32'h55, 0, 0, 4, 1, 0, 32'h11);
      addVec(0, 32'h00, 1, 0, 3, 0, 0, 32'h22);
      addVec(0, 32'h00, 1, 0, 2, 0, 0, 32'h33);
      addVec(0, 32'h00, 1, 0, 1, 0, 0, 32'h44);
      addVec(0, 32'h00, 1, 0, 0, 0, 1, 32'h00);
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ev, vecs[i].data, vecs[i].dr, vecs[i].fl, $sformatf("vec%0d", i));
         #1;
         checkVal($sformatf("vec%0d.count", i), 32'(count_o), 32'(vecs[i].exp_count));
         checkVal($sformatf("vec%0d.full", i),  32'(full_o),  32'(vecs[i].exp_full));
         checkVal($sformatf("vec%0d.enq_ready", i), 32'(enq_ready_o), 32'(!vecs[i].exp_full));
         checkVal($sformatf("vec%0d.empty", i), 32'(empty_o), 32'(vecs[i].exp_empty));
         checkVal($sformatf("vec%0d.data", i),  deq_data_o,   vecs[i].exp_data);
      end

      // Hold two entries while enqueuing and dequeuing together; the pointers
      // wrap and their flags toggle along the way.
      applyStimulus(1, 32'hB0, 0, 0, "wrap.fill0");
      applyStimulus(1, 32'hB1, 0, 0, "wrap.fill1");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 32'hC0 + 32'(i), 1, 0, $sformatf("wrap%0d", i));
         #1;
         checkVal($sformatf("wrap%0d.count", i), 32'(count_o), 32'd2);
         checkVal($sformatf("wrap%0d.data", i), deq_data_o, (i == 0) ? 32'hB1 : 32'hC0 + 32'(i - 1));
      end

      // Full queue with both sides active: only the dequeue fires.
      applyStimulus(1, 32'hD0, 0, 0, "full.fill0");
      applyStimulus(1, 32'hD1, 0, 0, "full.fill1");
      applyStimulus(1, 32'hEE, 1, 0, "full.both");
      #1;
      checkVal("full.both.count", 32'(count_o), 32'd3);
      checkVal("full.both.data",  deq_data_o,   32'hC9);

      // Flush at count 3 with a concurrent enqueue, then a fresh entry.
      applyStimulus(1, 32'hBB, 0, 1, "flush");
      #1;
      checkVal("flush.empty", 32'(empty_o), 32'd1);
      checkVal("flush.count", 32'(count_o), 32'd0);
      applyStimulus(1, 32'hAA, 0, 0, "flush.enq");
      #1;
      checkVal("flush.enq.data", deq_data_o, 32'hAA);
      applyStimulus(0, 32'h0, 1, 0, "flush.deq");

      // Asynchronous reset between edges at count 2.
      applyStimulus(1, 32'h61, 0, 0, "arst.fill0");
      applyStimulus(1, 32'h62, 0, 0, "arst.fill1");
      applyStimulus(0, 32'h0, 0, 0, "arst.idle");
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("arst.empty", 32'(empty_o), 32'd1);
      checkVal("arst.count", 32'(count_o), 32'd0);
      checkVal("arst.data",  deq_data_o,   32'd0);
      model_q.delete();
      #1;
      rst_n = 1'b1;
      applyStimulus(1, 32'h77, 0, 0, "arst.enq");
      #1;
      checkVal("arst.enq.data",  deq_data_o,   32'h77);
      checkVal("arst.enq.count", 32'(count_o), 32'd1);

      // Randomised traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(logic'($urandom_range(0, 1)), $urandom(),
                       logic'($urandom_range(0, 2) == 0 ? 1'b0 : 1'b1) & logic'($urandom_range(0, 1)),
                       logic'($urandom_range(0, 24) == 0),
                       $sformatf("rand%0d", i));
      end
      applyStimulus(0, 32'h0, 0, 0, "final");
      @(negedge clk);
      checkOutput("final.post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
